// File: rtl/aes_round_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : aes_round_ctrl
//  Purpose  : Round sequencer for the AES cipher datapath. Accepts one block
//             at a time, steps the state register through the initial
//             AddRoundKey, NR-1 full rounds and the final round (MixColumns
//             bypassed), then holds the ciphertext until the consumer
//             takes it and wipes the state register on the way out.
//  Revision : 1.0  initial release
// ============================================================================
module aes_round_ctrl #(
  parameter int NR    = 10,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             abort_i,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             state_en,
  output logic             state_clr,
  output logic             sel_init,
  output logic             skip_mix,
  output logic [3:0]       round_idx,
  output logic             busy,
  output logic [CNT_W-1:0] blk_cnt
);

  // Only the three AES key sizes are meaningful; anything else is a build error.
  if (!(NR == 10 || NR == 12 || NR == 14)) begin : g_bad_nr
    $error("aes_round_ctrl: NR must be 10, 12 or 14");
  end

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_round = 2'd1;
  localparam logic [1:0] c_st_final = 2'd2;
  localparam logic [1:0] c_st_done  = 2'd3;

  localparam logic [3:0]       c_nr      = 4'(NR);
  localparam logic [3:0]       c_nr_m1   = 4'(NR - 1);
  localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]       r_state;
  logic [3:0]       r_round_idx;
  logic [CNT_W-1:0] r_blk_cnt;

  logic w_idle;
  logic w_abort;
  logic w_out_hs;

  // Abort only means something while a block is in flight; in IDLE it is ignored.
  assign w_idle   = (r_state == c_st_idle);
  assign w_abort  = !CLR && abort_i && !w_idle;
  assign w_out_hs = !CLR && !abort_i && (r_state == c_st_done) && out_ready;

  // Sequencer state and round-key index; CLR wins over everything, abort beats completion.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      r_state     <= c_st_idle;
      r_round_idx <= 4'd0;
    end else begin
      case (r_state)
        c_st_idle: begin
          r_round_idx <= 4'd0;
          if (in_valid) begin
            r_state     <= c_st_round;
            r_round_idx <= 4'd1;
          end
        end
        c_st_round: begin
          if (abort_i) begin
            r_state     <= c_st_idle;
            r_round_idx <= 4'd0;
          end else begin
            r_round_idx <= r_round_idx + 4'd1;
            if (r_round_idx == c_nr_m1) begin
              r_state <= c_st_final;
            end
          end
        end
        c_st_final: begin
          if (abort_i) begin
            r_state     <= c_st_idle;
            r_round_idx <= 4'd0;
          end else begin
            r_state     <= c_st_done;
            r_round_idx <= c_nr;
          end
        end
        c_st_done: begin
          if (abort_i || out_ready) begin
            r_state     <= c_st_idle;
            r_round_idx <= 4'd0;
          end
        end
        default: begin
          r_state     <= c_st_idle;
          r_round_idx <= 4'd0;
        end
      endcase
    end
  end

  // Completed-block counter: counts output handshakes and sticks at all-ones.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      r_blk_cnt <= '0;
    end else if (w_out_hs && (r_blk_cnt != c_cnt_max)) begin
      r_blk_cnt <= r_blk_cnt + c_cnt_one;
    end
  end

  // Datapath controls decoded from the state; CLR and abort force a wipe with no write.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    state_en  = 1'b0;
    state_clr = 1'b0;
    sel_init  = w_idle;
    skip_mix  = (r_state == c_st_final);
    busy      = 1'b0;
    if (CLR) begin
      state_clr = 1'b1;
    end else if (w_abort) begin
      state_clr = 1'b1;
      busy      = 1'b1;
    end else begin
      busy = !w_idle;
      case (r_state)
        c_st_idle: begin
          in_ready = 1'b1;
          state_en = in_valid;
        end
        c_st_round, c_st_final: begin
          state_en = 1'b1;
        end
        c_st_done: begin
          out_valid = 1'b1;
          state_clr = w_out_hs;
        end
        default: begin
          state_en = 1'b0;
        end
      endcase
    end
  end

  assign round_idx = r_round_idx;
  assign blk_cnt   = r_blk_cnt;

endmodule
`default_nettype wire

// File: tb/tb_aes_round_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_aes_round_ctrl
//  Purpose  : Self-checking bench for aes_round_ctrl. Three instances share
//             clock/CLR/in_valid/out_ready (NR=10, NR=14, NR=10 with a 2-bit
//             counter); each has its own abort line. A per-instance model
//             tracks "cycles since the block was accepted" and derives every
//             output from that age.
//  Revision : 1.0  initial release
// ============================================================================
module tb_aes_round_ctrl;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic CLR, in_valid, out_ready;
  logic abort_v [3];
  logic irw [3], ovw [3], enw [3], clrw [3], selw [3], skw [3], bzw [3];
  logic [3:0]  ridx [3];
  logic [15:0] blk_cnt_a, blk_cnt_b;
  logic [1:0]  blk_cnt_c;

  aes_round_ctrl #(.NR(10), .CNT_W(16)) u_dut10 (
    .CLK(CLK), .CLR(CLR), .in_valid(in_valid), .in_ready(irw[0]), .abort_i(abort_v[0]),
    .out_valid(ovw[0]), .out_ready(out_ready), .state_en(enw[0]), .state_clr(clrw[0]),
    .sel_init(selw[0]), .skip_mix(skw[0]), .round_idx(ridx[0]), .busy(bzw[0]),
    .blk_cnt(blk_cnt_a));

  aes_round_ctrl #(.NR(14), .CNT_W(16)) u_dut14 (
    .CLK(CLK), .CLR(CLR), .in_valid(in_valid), .in_ready(irw[1]), .abort_i(abort_v[1]),
    .out_valid(ovw[1]), .out_ready(out_ready), .state_en(enw[1]), .state_clr(clrw[1]),
    .sel_init(selw[1]), .skip_mix(skw[1]), .round_idx(ridx[1]), .busy(bzw[1]),
    .blk_cnt(blk_cnt_b));

  aes_round_ctrl #(.NR(10), .CNT_W(2)) u_dut_c2 (
    .CLK(CLK), .CLR(CLR), .in_valid(in_valid), .in_ready(irw[2]), .abort_i(abort_v[2]),
    .out_valid(ovw[2]), .out_ready(out_ready), .state_en(enw[2]), .state_clr(clrw[2]),
    .sel_init(selw[2]), .skip_mix(skw[2]), .round_idx(ridx[2]), .busy(bzw[2]),
    .blk_cnt(blk_cnt_c));

  int checks   = 0;
  int failures = 0;

  // Reference model: age = -1 when idle, else cycles since the accepting cycle.
  int nrs  [3] = '{10, 14, 10};
  int caps [3] = '{65535, 65535, 3};
  int age  [3] = '{-1, -1, -1};
  int cnt  [3] = '{0, 0, 0};
  bit known = 1'b0;

  task automatic chk(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, idx, obs, exp);
    end
  endtask

  function automatic logic [31:0] getcnt(input int i);
    if (i == 0) return 32'(blk_cnt_a);
    if (i == 1) return 32'(blk_cnt_b);
    return 32'(blk_cnt_c);
  endfunction

  // One clock: check outputs against the model, take the edge, advance the model.
  task automatic run_cycle();
    #1;
    for (int i = 0; i < 3; i++) begin
      int  a, n;
      bit  idle, done;
      a    = age[i];
      n    = nrs[i];
      idle = (a < 0);
      done = (a == n + 1);
      if (known) begin
        chk("round_idx", i, 32'(ridx[i]), idle ? 32'd0 : 32'((a > n) ? n : a));
        chk("blk_cnt", i, getcnt(i), 32'(cnt[i]));
      end
      if (CLR) begin
        chk("clr_state_clr", i, 32'(clrw[i]), 32'd1);
        chk("clr_state_en", i, 32'(enw[i]), 32'd0);
        chk("clr_in_ready", i, 32'(irw[i]), 32'd0);
        chk("clr_out_valid", i, 32'(ovw[i]), 32'd0);
        chk("clr_busy", i, 32'(bzw[i]), 32'd0);
      end else begin
        chk("in_ready", i, 32'(irw[i]), 32'(idle));
        chk("busy", i, 32'(bzw[i]), 32'(!idle));
        chk("out_valid", i, 32'(ovw[i]), 32'(done && !abort_v[i]));
        chk("state_en", i, 32'(enw[i]),
            idle ? 32'(in_valid) : 32'(a >= 1 && a <= n && !abort_v[i]));
        chk("state_clr", i, 32'(clrw[i]),
            32'(!idle && (abort_v[i] || (done && out_ready))));
        chk("sel_init", i, 32'(selw[i]), 32'(idle));
        chk("skip_mix", i, 32'(skw[i]), 32'(a == n));
      end
    end
    @(posedge CLK);
    for (int i = 0; i < 3; i++) begin
      if (CLR) begin
        age[i] = -1;
        cnt[i] = 0;
      end else if (age[i] < 0) begin
        if (in_valid) age[i] = 1;
      end else if (abort_v[i]) begin
        age[i] = -1;
      end else if (age[i] == nrs[i] + 1) begin
        if (out_ready) begin
          age[i] = -1;
          if (cnt[i] < caps[i]) cnt[i] = cnt[i] + 1;
        end
      end else begin
        age[i] = age[i] + 1;
      end
    end
    if (CLR) known = 1'b1;
    @(negedge CLK);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat10, lat14, hold, sawov, found, nhs, acc0, acc1, ov14;
    logic [1:0] exp6 [5];
    exp6 = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    CLR = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) abort_v[i] = 1'b0;
    @(negedge CLK);

    // Reset held three cycles with in_valid high: CLR must override it.
    for (int k = 0; k < 3; k++) run_cycle();
    CLR = 1'b0; in_valid = 1'b0;
    #1;
    chk("rst_round_idx", 0, 32'(ridx[0]), 32'd0);
    chk("rst_blk_cnt", 0, 32'(blk_cnt_a), 32'd0);
    chk("rst_in_ready", 0, 32'(irw[0]), 32'd1);

    // Test 1: single block, latency NR+1, then one count.
    lat10 = -1; lat14 = -1;
    for (int k = 0; k < 21; k++) begin
      in_valid = (k == 0); out_ready = 1'b1;
      #1;
      if (ovw[0] && lat10 < 0) lat10 = k;
      if (ovw[1] && lat14 < 0) lat14 = k;
      run_cycle();
    end
    chk("t1_latency_nr10", 0, 32'(lat10), 32'd11);
    chk("t1_latency_nr14", 1, 32'(lat14), 32'd15);
    chk("t1_blk_cnt", 0, 32'(blk_cnt_a), 32'd1);

    // Test 2: consumer stalls five cycles in DONE.
    hold = 0;
    for (int k = 0; k < 21; k++) begin
      in_valid = (k == 0); out_ready = (k >= 16);
      #1;
      if (ovw[0] && !out_ready) hold++;
      if (k == 13) chk("t2_hold_round_idx", 0, 32'(ridx[0]), 32'd10);
      if (k == 16) chk("t2_hs_state_clr", 0, 32'(clrw[0]), 32'd1);
      run_cycle();
    end
    chk("t2_hold_cycles", 0, 32'(hold), 32'd5);

    // Test 3: abort at round 4, then a fresh block completes.
    for (int k = 0; k < 30; k++) begin
      in_valid = (k == 0 || k == 5); out_ready = 1'b1; abort_v[0] = (k == 4);
      #1;
      if (k == 4) begin
        chk("t3_abort_idx", 0, 32'(ridx[0]), 32'd4);
        chk("t3_abort_clr", 0, 32'(clrw[0]), 32'd1);
        chk("t3_abort_en", 0, 32'(enw[0]), 32'd0);
      end
      if (k == 5) begin
        chk("t3_after_ready", 0, 32'(irw[0]), 32'd1);
        chk("t3_after_cnt", 0, 32'(blk_cnt_a), 32'd2);
      end
      run_cycle();
    end
    abort_v[0] = 1'b0;
    chk("t3_final_cnt", 0, 32'(blk_cnt_a), 32'd3);

    // Test 4: CLR in the middle of a block.
    sawov = 0;
    for (int k = 0; k < 25; k++) begin
      CLR = (k == 7); in_valid = (k == 0); out_ready = 1'b1;
      #1;
      if (ovw[0]) sawov = 1;
      if (k == 7) chk("t4_idx_before", 0, 32'(ridx[0]), 32'd7);
      if (k == 8) begin
        chk("t4_idx_after", 0, 32'(ridx[0]), 32'd0);
        chk("t4_cnt_after", 0, 32'(blk_cnt_a), 32'd0);
        chk("t4_ready_after", 0, 32'(irw[0]), 32'd1);
      end
      run_cycle();
    end
    CLR = 1'b0;
    chk("t4_no_out_valid", 0, 32'(sawov), 32'd0);

    // Test 5a: NR=14 back-to-back blocks, accept period NR+2.
    CLR = 1'b1; run_cycle(); CLR = 1'b0;
    acc0 = -1; acc1 = -1; ov14 = -1;
    for (int k = 0; k < 40; k++) begin
      in_valid = 1'b1; out_ready = 1'b1;
      #1;
      if (irw[1]) begin
        if (acc0 < 0) acc0 = k;
        else if (acc1 < 0) acc1 = k;
      end
      if (ovw[1] && ov14 < 0) ov14 = k;
      run_cycle();
    end
    chk("t5_first_accept", 1, 32'(acc0), 32'd0);
    chk("t5_out_valid_cycle", 1, 32'(ov14), 32'd15);
    chk("t5_second_accept", 1, 32'(acc1), 32'd16);

    // Test 5b: abort together with out_ready in DONE does not count.
    CLR = 1'b1; in_valid = 1'b0; run_cycle(); CLR = 1'b0;
    found = 0;
    for (int k = 0; k < 40; k++) begin
      in_valid = (k == 0); out_ready = 1'b0;
      #1;
      if (ovw[1]) begin
        found = 1;
        break;
      end
      run_cycle();
    end
    chk("t5_reached_done", 1, 32'(found), 32'd1);
    abort_v[1] = 1'b1; out_ready = 1'b1;
    run_cycle();
    abort_v[1] = 1'b0; in_valid = 1'b0;
    chk("t5_abort_cnt", 1, 32'(blk_cnt_b), 32'd0);

    // Test 6: 2-bit counter saturates at 3.
    CLR = 1'b1; run_cycle(); CLR = 1'b0;
    nhs = 0;
    for (int k = 0; k < 62; k++) begin
      bit hs;
      in_valid = 1'b1; out_ready = 1'b1;
      #1;
      hs = ovw[2] && out_ready;
      run_cycle();
      if (hs && nhs < 5) begin
        chk("t6_blk_cnt_sat", nhs, 32'(blk_cnt_c), 32'(exp6[nhs]));
        nhs++;
      end
    end
    chk("t6_block_count", 2, 32'(nhs), 32'd5);

    // Randomized traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      CLR       = ($urandom_range(0, 299) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      for (int i = 0; i < 3; i++)
        abort_v[i] = (age[i] >= 0) && ($urandom_range(0, 39) == 0);
      run_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
